keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans the 4x4 hex keypad, debounces both press and release, and emits a registered hex key code with a one-cycle newNum strobe for the display/number-shift logic downstream.
- Sits directly behind the FPGA pin wrapper. It drives rows and reads cols as active-high signals. Pin inversion and the row/col pull-ups stay in the wrapper.
- Only one key is tracked at a time. The first debounced key locks out all others until it is released.

Parameters:
- SCAN_DIV, 2400: clk cycles each row is driven before its cols are sampled. Must be >= 4.
- DEBOUNCE_CYCLES, 480000: consecutive stable cycles required to accept a press or a release. Must be >= 2.
- REPEAT_CYCLES, 24000000: auto-repeat period. Used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock (HSOSC, 48 MHz)
- reset  input  1  asynchronous, active-low reset
- cols  input  4  keypad columns, active-high, asynchronous to clk
- rows  output  4  one-hot row drive, active-high
- key  output  4  hex code of the last accepted key
- newNum  output  1  one-cycle strobe when key takes a new value
- idle  output  1  high while in SCAN
- pressed  output  1  high while a key is locked (HELD or RELEASE)

Behaviour:
- Reset: asynchronous, active-low. While reset is low:
  - rows=4'b0001, rowIdx=0, key=0, newNum=0, idle=1, pressed=0.
  - State=SCAN, all counters 0, synchronizer flops 0.
- Input synchronizer: cols passes through a 2-flop synchronizer to give colsS. All decisions use colsS only.
- Key map, indexed [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Registers: dwell counter, debounce counter, rowIdx[1:0], lockRow[1:0], lockCol[1:0]. Counter widths use $clog2 of the parameter.
- State SCAN:
  - rows = onehot(rowIdx). The dwell counter increments every cycle.
  - On the cycle dwell==SCAN_DIV-1, sample colsS and clear dwell.
  - Exactly one bit of colsS set: latch lockRow=rowIdx and lockCol=that bit's index, clear the debounce counter, go to DEBOUNCE. rows stays on the locked row.
  - Zero bits or more than one bit set: rowIdx advances, wrapping 3->0.
- State DEBOUNCE (rows held on lockRow):
  - colsS[lockCol]=1: debounce counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the column still high: go to HELD. On that same cycle, key is registered from the map and newNum pulses high for exactly one cycle.
  - colsS[lockCol]=0 on any cycle: return to SCAN with rowIdx=lockRow+1 (wrapping). No newNum pulse.
- State HELD:
  - pressed=1. Other columns and rows are ignored.
  - colsS[lockCol]=0: clear the debounce counter and go to RELEASE.
- State RELEASE:
  - pressed=1.
  - colsS[lockCol]=1: return to HELD. No newNum.
  - Low for DEBOUNCE_CYCLES consecutive cycles: go to SCAN with rowIdx=lockRow+1.
- Output rules:
  - idle = (state==SCAN).
  - newNum fires only on the DEBOUNCE->HELD transition.
  - key changes only when newNum fires and otherwise holds its value indefinitely.
- Outputs are registered. There are no combinational paths from cols to any output.
- Reset asserted mid-operation aborts the state immediately. No newNum is generated on reset exit.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts up.
  - On reaching REPEAT_CYCLES-1, newNum pulses for one cycle with key unchanged, and the counter clears.
  - The counter also clears on entering HELD from DEBOUNCE. It is frozen, not cleared, while in RELEASE.
- Undefined: no repeat counter exists and REPEAT_CYCLES is unused. Exactly one newNum pulse occurs per physical press.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8 (REPEAT_CYCLES=20 where noted).
1. Reset:
   - Stimulus: hold reset=0 with cols=4'b1111.
   - Response: rows=0001, key=0, newNum=0, idle=1, pressed=0. After release, rows steps 0001->0010->0100->1000->0001 every 4 cycles while cols=0.
2. Clean press of '5':
   - Stimulus: cols[1]=1 only while rows=0010, held for 40 cycles.
   - Response: exactly one newNum pulse, key=4'h5, pressed=1, idle=0 after the pulse.
3. Press bounce:
   - Stimulus: cols[2]=1 for 3 cycles during rows=1000 dwell, then 0.
   - Response: no newNum, key unchanged, back in SCAN with rows=0001.
4. Multi-key:
   - Stimulus A: cols=4'b0011 during rows=0001. Response: no lock, scanning continues.
   - Stimulus B: while '1' is HELD, assert cols[3] as well. Response: no second pulse, key stays 4'h1.
5. Release bounce, then clean release:
   - Stimulus: '9' held, then column low for 3 cycles, high again, low for 10 cycles.
   - Response: single newNum total; pressed drops and idle=1 only after the 8-cycle low run; scan resumes at rows=1000.
6. KEYPAD_REPEAT_EN with REPEAT_CYCLES=20:
   - Stimulus A: hold 'D' for 70 cycles past acceptance. Response: newNum at acceptance, then every 20 cycles, key=4'hD throughout.
   - Stimulus B: reset asserted mid-HELD. Response: immediate return to reset values with no pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row scan, press/release debounce, single-key lockout.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
`timescale 1ns/1ps
module keypad_scanner #(
   parameter int unsigned SCAN_DIV        = 2400,
   parameter int unsigned DEBOUNCE_CYCLES = 480000,
   parameter int unsigned REPEAT_CYCLES   = 24000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic [3:0] key,
   output logic       newNum,
   output logic       idle,
   output logic       pressed
);

   localparam int unsigned DW_W = $clog2(SCAN_DIV);
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);

   if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("keypad_scanner: illegal parameter value");
   end

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_e;

   state_e          state_q, state_d;
   logic [DW_W-1:0] dwell_q, dwell_d;
   logic [DB_W-1:0] deb_q, deb_d;
   logic [1:0]      row_idx_q, row_idx_d;
   logic [1:0]      lock_row_q, lock_row_d;
   logic [1:0]      lock_col_q, lock_col_d;
   logic [3:0]      sync1_q, cols_s_q;
   logic [3:0]      rows_q, rows_d;
   logic [3:0]      key_q, key_d;
   logic            new_num_q, pulse_d;
   logic            idle_q, pressed_q;
   logic            one_hot;
   logic [1:0]      col_idx;
   logic            lock_hit;
`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RP_W = $clog2(REPEAT_CYCLES);
   logic [RP_W-1:0] rep_q, rep_d;
`endif

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
         4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Single-column detect on the synchronized columns; multi-key presses are ignored
   always_comb begin
      one_hot = 1'b1;
      col_idx = 2'd0;
      case (cols_s_q)
         4'b0001: col_idx = 2'd0;
         4'b0010: col_idx = 2'd1;
         4'b0100: col_idx = 2'd2;
         4'b1000: col_idx = 2'd3;
         default: one_hot = 1'b0;
      endcase
   end

   assign lock_hit = cols_s_q[lock_col_q];

   always_comb begin
      state_d    = state_q;
      dwell_d    = dwell_q;
      deb_d      = deb_q;
      row_idx_d  = row_idx_q;
      lock_row_d = lock_row_q;
      lock_col_d = lock_col_q;
      key_d      = key_q;
      pulse_d    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d      = rep_q;
`endif
      case (state_q)
         S_SCAN: begin
            dwell_d = dwell_q + DW_W'(1);
            if (dwell_q == DW_W'(SCAN_DIV - 1)) begin
               dwell_d = '0;
               if (one_hot) begin
                  lock_row_d = row_idx_q;
                  lock_col_d = col_idx;
                  deb_d      = '0;
                  state_d    = S_DEBOUNCE;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
         end
         S_DEBOUNCE: begin
            if (!lock_hit) begin
               state_d   = S_SCAN;
               row_idx_d = lock_row_q + 2'd1;
            end else if (deb_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               state_d = S_HELD;
               key_d   = key_map(lock_row_q, lock_col_q);
               pulse_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
               rep_d   = '0;
`endif
            end else begin
               deb_d = deb_q + DB_W'(1);
            end
         end
         S_HELD: begin
            if (!lock_hit) begin
               deb_d   = '0;
               state_d = S_RELEASE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_q == RP_W'(REPEAT_CYCLES - 1)) begin
               rep_d   = '0;
               pulse_d = 1'b1;
            end else begin
               rep_d = rep_q + RP_W'(1);
            end
`endif
         end
         default: begin
            // Repeat counter intentionally frozen here so a release blip does not restart it
            if (lock_hit) begin
               state_d = S_HELD;
            end else if (deb_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               state_d   = S_SCAN;
               row_idx_d = lock_row_q + 2'd1;
            end else begin
               deb_d = deb_q + DB_W'(1);
            end
         end
      endcase
      rows_d = 4'b0001 << ((state_d == S_SCAN) ? row_idx_d : lock_row_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_SCAN;
         dwell_q    <= '0;
         deb_q      <= '0;
         row_idx_q  <= 2'd0;
         lock_row_q <= 2'd0;
         lock_col_q <= 2'd0;
         sync1_q    <= 4'b0;
         cols_s_q   <= 4'b0;
         rows_q     <= 4'b0001;
         key_q      <= 4'h0;
         new_num_q  <= 1'b0;
         idle_q     <= 1'b1;
         pressed_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         dwell_q    <= dwell_d;
         deb_q      <= deb_d;
         row_idx_q  <= row_idx_d;
         lock_row_q <= lock_row_d;
         lock_col_q <= lock_col_d;
         sync1_q    <= cols;
         cols_s_q   <= sync1_q;
         rows_q     <= rows_d;
         key_q      <= key_d;
         new_num_q  <= pulse_d;
         idle_q     <= (state_d == S_SCAN);
         pressed_q  <= (state_d == S_HELD) || (state_d == S_RELEASE);
`ifdef KEYPAD_REPEAT_EN
         rep_q      <= rep_d;
`endif
      end
   end

   assign rows    = rows_q;
   assign key     = key_q;
   assign newNum  = new_num_q;
   assign idle    = idle_q;
   assign pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model gates cols by the driven row,
// expected key codes are queued per press and checked on every newNum pulse.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEB      = 8;
   localparam int unsigned REP      = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cols;
   logic [3:0] rows;
   logic [3:0] key;
   logic       newNum;
   logic       idle;
   logic       pressed;

   logic [3:0] key_mat [4];
   logic       force_en;
   logic [3:0] force_cols;

   int checks   = 0;
   int failures = 0;
   logic [3:0] exp_q [$];

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES  (REP)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .cols   (cols),
      .rows   (rows),
      .key    (key),
      .newNum (newNum),
      .idle   (idle),
      .pressed(pressed)
   );

   // Physical keypad: a closed key connects its row drive to its column
   always_comb begin
      cols = force_en ? force_cols : 4'b0000;
      if (!force_en)
         for (int r = 0; r < 4; r++)
            if (rows[r]) cols = cols | key_mat[r];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && newNum === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_newNum: got pulse with key=%0h expected no pulse", key);
         end else begin
            check("newNum_key", 32'(key), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic wait_state(input string name, input logic want_p, input logic want_i, input int budget);
      int n;
      n = 0;
      while (!(pressed === want_p && idle === want_i) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'({pressed, idle}), 32'({want_p, want_i}));
   endtask

   task automatic wait_rows(input string name, input logic [3:0] want, input int budget);
      int n;
      n = 0;
      while (rows !== want && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(rows), 32'(want));
   endtask

   initial begin
      reset      = 1'b0;
      force_en   = 1'b1;
      force_cols = 4'hF;
      for (int r = 0; r < 4; r++) key_mat[r] = 4'b0000;

      // Reset values with all columns asserted
      repeat (3) @(negedge clk);
      check("rst_rows", 32'(rows), 32'h1);
      check("rst_key", 32'(key), 32'h0);
      check("rst_newNum", 32'(newNum), 32'h0);
      check("rst_idle", 32'(idle), 32'h1);
      check("rst_pressed", 32'(pressed), 32'h0);

      // Free-running scan, 4 cycles per row
      force_en = 1'b0;
      reset    = 1'b1;
      repeat (2) @(negedge clk);
      check("scan_row0", 32'(rows), 32'h1);
      repeat (4) @(negedge clk);
      check("scan_row1", 32'(rows), 32'h2);
      repeat (4) @(negedge clk);
      check("scan_row2", 32'(rows), 32'h4);
      repeat (4) @(negedge clk);
      check("scan_row3", 32'(rows), 32'h8);
      repeat (4) @(negedge clk);
      check("scan_wrap", 32'(rows), 32'h1);

      // Clean press of '5'
      exp_q.push_back(4'h5);
      key_mat[1][1] = 1'b1;
      wait_state("press5_accept", 1'b1, 1'b0, 60);
      repeat (15) @(negedge clk);
      check("press5_key", 32'(key), 32'h5);
      check("press5_held", 32'({pressed, idle}), 32'b10);
      key_mat[1][1] = 1'b0;
      wait_state("press5_release", 1'b0, 1'b1, 40);

      // Press bounce on row 3: too short to debounce
      wait_rows("bounce_row2", 4'b0100, 40);
      wait_rows("bounce_row3", 4'b1000, 10);
      key_mat[3][2] = 1'b1;
      repeat (3) @(negedge clk);
      key_mat[3][2] = 1'b0;
      repeat (4) @(negedge clk);
      check("bounce_rows", 32'(rows), 32'h1);
      check("bounce_idle", 32'({pressed, idle}), 32'b01);
      check("bounce_key", 32'(key), 32'h5);

      // Two keys on one row never lock
      key_mat[0][0] = 1'b1;
      key_mat[0][1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         repeat (4) @(negedge clk);
         check("multi_nolock", 32'({pressed, idle}), 32'b01);
      end
      key_mat[0] = 4'b0000;
      repeat (4) @(negedge clk);

      // '1' held, then 'A' on the same row is ignored
      exp_q.push_back(4'h1);
      key_mat[0][0] = 1'b1;
      wait_state("press1_accept", 1'b1, 1'b0, 60);
      key_mat[0][3] = 1'b1;
      repeat (15) @(negedge clk);
      check("lockout_key", 32'(key), 32'h1);
      check("lockout_held", 32'(pressed), 32'h1);
      key_mat[0] = 4'b0000;
      wait_state("press1_release", 1'b0, 1'b1, 40);

      // '9' with a release bounce, then a clean release
      exp_q.push_back(4'h9);
      key_mat[2][2] = 1'b1;
      wait_state("press9_accept", 1'b1, 1'b0, 60);
      repeat (5) @(negedge clk);
      key_mat[2][2] = 1'b0;
      repeat (3) @(negedge clk);
      key_mat[2][2] = 1'b1;
      repeat (6) @(negedge clk);
      check("relbounce_held", 32'({pressed, idle}), 32'b10);
      key_mat[2][2] = 1'b0;
      repeat (9) @(negedge clk);
      check("release_pending", 32'({pressed, idle}), 32'b10);
      repeat (2) @(negedge clk);
      check("release_done", 32'({pressed, idle}), 32'b01);
      check("release_rows", 32'(rows), 32'h8);
      check("release_key", 32'(key), 32'h9);

      // 'D' held 70 cycles past acceptance, then reset mid-hold
      exp_q.push_back(4'hD);
`ifdef KEYPAD_REPEAT_EN
      exp_q.push_back(4'hD);
      exp_q.push_back(4'hD);
      exp_q.push_back(4'hD);
`endif
      key_mat[3][3] = 1'b1;
      wait_state("pressD_accept", 1'b1, 1'b0, 60);
      repeat (70) @(negedge clk);
      check("pressD_key", 32'(key), 32'hD);
      reset = 1'b0;
      #1;
      check("midrst_rows", 32'(rows), 32'h1);
      check("midrst_key", 32'(key), 32'h0);
      check("midrst_newNum", 32'(newNum), 32'h0);
      check("midrst_state", 32'({pressed, idle}), 32'b01);
      key_mat[3][3] = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      check("postrst_state", 32'({pressed, idle}), 32'b01);
      check("postrst_key", 32'(key), 32'h0);

      check("pending_pulses", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
